nibble_serial_add_ctrl: RTL and testbench

Sequencer that performs a (4*NIBBLES)-bit add or subtract by time-multiplexing the team's existing 4-bit ripple-carry adder, one nibble per clock, LSB nibble first. It sits on both sides of that adder. Upstream, it latches wide operands over a valid/ready handshake and drives the adder's A/B/C_IN. Downstream, it captures the adder's SUM/C_OUT into a result register and presents the wide result over a second valid/ready handshake.

---
 rtl/nibble_serial_add_ctrl.sv | 155 +++++++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_add_ctrl.sv
// Serial wide adder/subtractor: feeds an external 4-bit ripple adder one nibble per clock,
// LSB first, and collects the wide sum behind valid/ready handshakes on both sides.
module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    input  logic [4*NIBBLES-1:0]   OP_A,
    input  logic [4*NIBBLES-1:0]   OP_B,
    input  logic                   OP_CIN,
    input  logic                   SUB,
    output logic [3:0]             ADD_A,
    output logic [3:0]             ADD_B,
    output logic                   ADD_CIN,
    input  logic [3:0]             ADD_SUM,
    input  logic                   ADD_COUT,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY,
    output logic [4*NIBBLES-1:0]   RESULT,
    output logic                   COUT,
    output logic                   OVF
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic               carry_q, carry_d;
    logic               msb_a_q, msb_a_d;
    logic               msb_b_q, msb_b_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [W-1:0]       result_q, result_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;

    // State and datapath registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            msb_a_q     <= 1'b0;
            msb_b_q     <= 1'b0;
            idx_q       <= '0;
            result_q    <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            msb_a_q     <= msb_a_d;
            msb_b_q     <= msb_b_d;
            idx_q       <= idx_d;
            result_q    <= result_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        msb_a_d     = msb_a_q;
        msb_b_d     = msb_b_q;
        idx_d       = idx_q;
        result_d    = result_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (IN_VALID) begin
                    // Subtraction is A + ~B + 1, so B is inverted once here and the +1 rides in on the carry.
                    a_d     = OP_A;
                    b_d     = SUB ? ~OP_B : OP_B;
                    carry_d = SUB ? 1'b1 : OP_CIN;
                    msb_a_d = OP_A[W-1];
                    msb_b_d = SUB ? ~OP_B[W-1] : OP_B[W-1];
                    idx_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d = {4'h0, a_q[W-1:4]};
                b_d = {4'h0, b_q[W-1:4]};
                result_d[{idx_q, 2'b00} +: 4] = ADD_SUM;
                carry_d = ADD_COUT;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    cout_d      = ADD_COUT;
                    ovf_d       = (msb_a_q == msb_b_q) && (ADD_SUM[3] != msb_a_q);
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (OUT_READY) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // Adder operands are only presented while a nibble is in flight
    always_comb begin
        if (state_q == RUN) begin
            ADD_A   = a_q[3:0];
            ADD_B   = b_q[3:0];
            ADD_CIN = carry_q;
        end else begin
            ADD_A   = 4'h0;
            ADD_B   = 4'h0;
            ADD_CIN = 1'b0;
        end
    end

    assign IN_READY  = (state_q == IDLE);
    assign OUT_VALID = out_valid_q;
    assign RESULT    = result_q;
    assign COUT      = cout_q;
    assign OVF       = ovf_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Bench for nibble_serial_add_ctrl: directed vectors plus randomized operations checked
// against an integer-arithmetic reference model; the bench also plays the 4-bit adder.
module tb_nibble_serial_add_ctrl;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   op_a = '0;
    logic [W-1:0]   op_b = '0;
    logic           op_cin = 1'b0;
    logic           sub_i = 1'b0;
    logic [3:0]     add_a, add_b, add_sum;
    logic           add_cin, add_cout;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [W-1:0]   result;
    logic           cout, ovf;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'h0, add_cin};

    nibble_serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
        .CLK(clk), .RST(rst),
        .IN_VALID(in_valid), .IN_READY(in_ready),
        .OP_A(op_a), .OP_B(op_b), .OP_CIN(op_cin), .SUB(sub_i),
        .ADD_A(add_a), .ADD_B(add_b), .ADD_CIN(add_cin),
        .ADD_SUM(add_sum), .ADD_COUT(add_cout),
        .OUT_VALID(out_valid), .OUT_READY(out_ready),
        .RESULT(result), .COUT(cout), .OVF(ovf)
    );

    // Reference: plain signed/unsigned integer arithmetic on the whole operands.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, input logic sub,
                                  output logic [W-1:0] r, output logic c, output logic o);
        longint md, ua, ub, sa, sb, full, sres;
        md = longint'(1) << W;
        ua = longint'(a);
        ub = longint'(b);
        sa = a[W-1] ? ua - md : ua;
        sb = b[W-1] ? ub - md : ub;
        if (sub) begin
            full = ua - ub;
            sres = sa - sb;
            c    = (ua >= ub);
        end else begin
            full = ua + ub + longint'(cin);
            sres = sa + sb + longint'(cin);
            c    = (full >= md);
        end
        r = W'(full);
        o = (sres > (md / 2) - 1) || (sres < -(md / 2));
    endfunction

    // Drives one operation through both handshakes and returns what the DUT produced.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic sub, input int ready_delay,
                         output logic [W-1:0] r, output logic c, output logic o,
                         output int lat, output int acc_cyc,
                         output logic [NIBBLES-1:0] cins, output bit tmo);
        int w;
        w = 0; tmo = 1'b0; lat = 0; cins = '0;
        while (!in_ready && w < 20) begin @(posedge clk); #1; w++; end
        if (!in_ready) tmo = 1'b1;
        op_a = a; op_b = b; op_cin = cin; sub_i = sub; in_valid = 1'b1;
        @(posedge clk); #1;
        acc_cyc = cyc;
        in_valid = 1'b0;
        while (!out_valid && lat < 50) begin
            if (lat < NIBBLES) cins[lat] = add_cin;
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) tmo = 1'b1;
        r = result; c = cout; o = ovf;
        repeat (ready_delay) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_handshake: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
        n_tests++;
        if (result !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
            n_fail++; $display("FAIL reset_result: result=%h cout=%b ovf=%b expected 0/0/0", result, cout, ovf);
        end
        n_tests++;
        if (add_a !== 4'h0 || add_b !== 4'h0 || add_cin !== 1'b0) begin
            n_fail++; $display("FAIL reset_adder_drive: a=%h b=%h cin=%b expected 0", add_a, add_b, add_cin);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [W-1:0] va [7] = '{16'h00FF, 16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0005, 16'h8000};
        logic [W-1:0] vb [7] = '{16'h0001, 16'h0001, 16'h0000, 16'h0001, 16'h8000, 16'h0007, 16'h0001};
        logic         vc [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic         vs [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [W-1:0] er [7] = '{16'h0100, 16'h0000, 16'h0000, 16'h8000, 16'h0000, 16'hFFFE, 16'h7FFF};
        logic         ec [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic         eo [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [W-1:0] r; logic c, o; int lat, acc; logic [NIBBLES-1:0] cins; bit tmo;
        for (int i = 0; i < 7; i++) begin
            do_op(va[i], vb[i], vc[i], vs[i], 0, r, c, o, lat, acc, cins, tmo);
            n_tests++;
            if (tmo || r !== er[i] || c !== ec[i] || o !== eo[i]) begin
                n_fail++;
                $display("FAIL directed_%0d: result=%h cout=%b ovf=%b tmo=%0d expected %h/%b/%b",
                         i, r, c, o, tmo, er[i], ec[i], eo[i]);
            end
            n_tests++;
            if (lat !== NIBBLES) begin
                n_fail++; $display("FAIL directed_latency_%0d: got %0d expected %0d", i, lat, NIBBLES);
            end
            if (i == 0) begin
                n_tests++;
                if (cins !== 4'b0110) begin
                    n_fail++; $display("FAIL add_cin_sequence: got %b expected 0110 (bit0 first)", cins);
                end
            end
            n_tests++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                n_fail++; $display("FAIL directed_release_%0d: in_ready=%b out_valid=%b expected 1/0", i, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] er, er2, p, q; logic ec, eo, ec2, eo2; int w; bit bad;
        while (!in_ready) begin @(posedge clk); #1; end
        model(16'h1234, 16'h0F0F, 1'b1, 1'b0, er, ec, eo);
        op_a = 16'h1234; op_b = 16'h0F0F; op_cin = 1'b1; sub_i = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        w = 0;
        while (!out_valid && w < 50) begin @(posedge clk); #1; w++; end
        bad = 1'b0;
        for (int k = 0; k < 5; k++) begin
            op_a = W'($urandom); op_b = W'($urandom); op_cin = 1'($urandom);
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== er || cout !== ec || ovf !== eo) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin
            n_fail++; $display("FAIL backpressure_hold: result=%h cout=%b ovf=%b valid=%b ready=%b expected %h/%b/%b/1/0",
                               result, cout, ovf, out_valid, in_ready, er, ec, eo);
        end
        p = W'($urandom); q = W'($urandom);
        op_a = p; op_b = q; op_cin = 1'b0; sub_i = 1'b1;
        model(p, q, 1'b0, 1'b1, er2, ec2, eo2);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL backpressure_release: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL backpressure_next_accept: in_ready=%b expected 0", in_ready);
        end
        w = 0;
        while (!out_valid && w < 50) begin @(posedge clk); #1; w++; end
        n_tests++;
        if (out_valid !== 1'b1 || result !== er2 || cout !== ec2 || ovf !== eo2) begin
            n_fail++; $display("FAIL backpressure_next_result: result=%h cout=%b ovf=%b valid=%b expected %h/%b/%b/1",
                               result, cout, ovf, out_valid, er2, ec2, eo2);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] r; logic c, o; int lat, acc; logic [NIBBLES-1:0] cins; bit tmo, seen;
        while (!in_ready) begin @(posedge clk); #1; end
        op_a = 16'hFFFF; op_b = 16'h0001; op_cin = 1'b0; sub_i = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || result !== '0 || in_ready !== 1'b1 || add_cin !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_run: valid=%b result=%h ready=%b add_cin=%b expected 0/0000/1/0",
                               out_valid, result, in_ready, add_cin);
        end
        #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) seen = 1'b1;
        end
        n_tests++;
        if (seen) begin
            n_fail++; $display("FAIL reset_no_spurious: got valid/not-ready after abort expected idle");
        end
        do_op(16'h1234, 16'h1111, 1'b0, 1'b0, 0, r, c, o, lat, acc, cins, tmo);
        n_tests++;
        if (tmo || r !== 16'h2345 || c !== 1'b0 || o !== 1'b0) begin
            n_fail++; $display("FAIL reset_followup: result=%h cout=%b ovf=%b tmo=%0d expected 2345/0/0", r, c, o, tmo);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, r, er; logic cin, sub, c, o, ec, eo; int lat, acc; logic [NIBBLES-1:0] cins; bit tmo;
        for (int i = 0; i < 40; i++) begin
            a = W'($urandom); b = (i % 8 == 3) ? a : W'($urandom);
            cin = 1'($urandom); sub = 1'($urandom);
            model(a, b, cin, sub, er, ec, eo);
            do_op(a, b, cin, sub, $urandom_range(0, 3), r, c, o, lat, acc, cins, tmo);
            n_tests++;
            if (tmo || r !== er || c !== ec || o !== eo || lat !== NIBBLES) begin
                n_fail++;
                $display("FAIL random_%0d: a=%h b=%h cin=%b sub=%b got %h/%b/%b lat=%0d expected %h/%b/%b lat=%0d",
                         i, a, b, cin, sub, r, c, o, lat, er, ec, eo, NIBBLES);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a, b, r, er; logic sub, c, o, ec, eo; int lat, acc, prev; logic [NIBBLES-1:0] cins; bit tmo;
        prev = -1;
        for (int i = 0; i < 4; i++) begin
            a = W'($urandom); b = W'($urandom); sub = 1'(i);
            model(a, b, 1'b0, sub, er, ec, eo);
            do_op(a, b, 1'b0, sub, 0, r, c, o, lat, acc, cins, tmo);
            n_tests++;
            if (tmo || r !== er || c !== ec || o !== eo) begin
                n_fail++; $display("FAIL b2b_result_%0d: got %h/%b/%b expected %h/%b/%b", i, r, c, o, er, ec, eo);
            end
            if (prev >= 0) begin
                n_tests++;
                if (acc - prev !== NIBBLES + 2) begin
                    n_fail++; $display("FAIL b2b_throughput_%0d: got %0d cycles expected %0d", i, acc - prev, NIBBLES + 2);
                end
            end
            prev = acc;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
